// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, packet type and NOP encoding for the fetch queue
//
// Contents:
//   PC_W, INSTR_W  packet field widths
//   fetch_pkt_t    {pc, instr} packet as stored and presented to decode
//   NOP_INSTR      instruction word shown when no packet is valid
package fetch_queue_pkg;

  localparam int PC_W    = 20;
  localparam int INSTR_W = 20;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 20'h00000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - packet storage array for the fetch queue
//
// Simple dual-port array of DEPTH packets: one synchronous write port and
// one asynchronous read port, both addressed by entry index.
//
// Ports:
//   clk      in   write clock
//   wr_en    in   write wr_data into entry wr_idx at the rising edge
//   wr_idx   in   write entry index
//   wr_data  in   packet to store
//   rd_idx   in   read entry index
//   rd_data  out  packet at rd_idx (combinational)
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  fetch_pkt_t       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output fetch_pkt_t       rd_data
);

  // Contents are not reset; the pointers in the parent decide what is valid.
  fetch_pkt_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction queue between fetch and decode
//
// Buffers up to DEPTH {pc, instr} packets. Fetch pushes with in_valid/in_ready,
// decode pops with out_valid/out_ready. A taken branch raises flush, which
// empties the queue and drops any same-cycle push.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present the incoming
// packet combinationally on out_* when the queue is empty.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   flush      in   discard all entries and the same-cycle push
//   in_valid   in   fetch offers a packet
//   in_ready   out  queue not full (registered state only)
//   in_pc      in   offered PC
//   in_instr   in   offered instruction
//   out_valid  out  head packet available
//   out_ready  in   decode consumes the head
//   out_pc     out  head PC, zero when out_valid=0
//   out_instr  out  head instruction, NOP when out_valid=0
//   count      out  current occupancy 0..DEPTH
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PTR_W-1:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic       empty;
  logic       full;
  logic       bypass;
  logic       bypass_take;
  logic       push;
  logic       pop;
  fetch_pkt_t in_pkt;
  fetch_pkt_t rd_pkt;
  fetch_pkt_t head;
  logic       head_valid;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                 (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // Derived from pointer flops only, so decode can never loop back into fetch.
  assign in_ready = !full;

  assign in_pkt.pc    = in_pc;
  assign in_pkt.instr = in_instr;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: hand the incoming packet straight to decode. If decode takes
  // it this cycle it is never stored; otherwise it is written as usual.
  assign bypass      = empty && in_valid && !flush;
  assign bypass_take = bypass && out_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid && in_ready && !flush && !bypass_take;
  // Pops only ever come from storage; a bypassed packet leaves the pointers alone.
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    head_valid = !empty;
    head       = rd_pkt;
    if (bypass) begin
      head_valid = 1'b1;
      head       = in_pkt;
    end
  end

  assign out_valid = head_valid;
  assign out_pc    = head_valid ? head.pc    : '0;
  assign out_instr = head_valid ? head.instr : NOP_INSTR;

  // Pointer widths are a power of two, so plain subtraction wraps correctly.
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !reset),
    .wr_idx  (wr_ptr_q[IDX_W-1:0]),
    .wr_data (in_pkt),
    .rd_idx  (rd_ptr_q[IDX_W-1:0]),
    .rd_data (rd_pkt)
  );

endmodule
